// File: rtl/seven_segment.sv
// Registered hex-digit to seven-segment decoder for the common-anode display.
// Reset and blank force every segment dark; polarity is selected by ACTIVE_LOW.
module seven_segment #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data,
    input  logic       blank,
    output logic [6:0] segment
);

    localparam logic [6:0] DARK_LO = 7'b1111111;
    localparam logic [6:0] DARK    = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    logic [6:0] pattern_lo;
    logic [6:0] seg_d;
    logic [6:0] seg_q;

    // Patterns are held active-low (g..a); the other polarity is a plain inversion.
    always_comb begin
        pattern_lo = DARK_LO;
        case (data)
            4'h0:    pattern_lo = 7'b1000000;
            4'h1:    pattern_lo = 7'b1111001;
            4'h2:    pattern_lo = 7'b0100100;
            4'h3:    pattern_lo = 7'b0110000;
            4'h4:    pattern_lo = 7'b0011001;
            4'h5:    pattern_lo = 7'b0010010;
            4'h6:    pattern_lo = 7'b0000010;
            4'h7:    pattern_lo = 7'b1111000;
            4'h8:    pattern_lo = 7'b0000000;
            4'h9:    pattern_lo = 7'b0010000;
            4'hA:    pattern_lo = 7'b0001000;
            4'hB:    pattern_lo = 7'b0000011;
            4'hC:    pattern_lo = 7'b1000110;
            4'hD:    pattern_lo = 7'b0100001;
            4'hE:    pattern_lo = 7'b0000110;
            4'hF:    pattern_lo = 7'b0001110;
            default: pattern_lo = DARK_LO;
        endcase
    end

    always_comb begin
        seg_d = blank ? DARK_LO : pattern_lo;
        if (!ACTIVE_LOW) begin
            seg_d = ~seg_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= DARK;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign segment = seg_q;

endmodule

// File: tb/tb_seven_segment.sv
// Directed bench for seven_segment: both polarities, reset, blank, latency.
module tb_seven_segment;

    logic       clk;
    logic       rst_n;
    logic [3:0] data;
    logic       blank;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] data;
        logic       blank;
        logic [6:0] exp_lo;
    } vec_t;

    vec_t vecs[20];

    seven_segment #(.ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst_n(rst_n), .data(data), .blank(blank), .segment(seg_lo)
    );

    seven_segment #(.ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .data(data), .blank(blank), .segment(seg_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] got,
                         input logic [6:0] exp);
        int bad;
        checks++;
        if (got !== exp) begin
            bad = -1;
            for (int b = 0; b < 7; b++) begin
                if (bad < 0 && got[b] !== exp[b]) bad = b;
            end
            failures++;
            $display("FAIL %s: got %b expected %b (first bad bit %0d)",
                     name, got, exp, bad);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0]  = '{4'h0, 1'b0, 7'b1000000};
        vecs[1]  = '{4'h1, 1'b0, 7'b1111001};
        vecs[2]  = '{4'h2, 1'b0, 7'b0100100};
        vecs[3]  = '{4'h3, 1'b0, 7'b0110000};
        vecs[4]  = '{4'h4, 1'b0, 7'b0011001};
        vecs[5]  = '{4'h5, 1'b0, 7'b0010010};
        vecs[6]  = '{4'h6, 1'b0, 7'b0000010};
        vecs[7]  = '{4'h7, 1'b0, 7'b1111000};
        vecs[8]  = '{4'h8, 1'b0, 7'b0000000};
        vecs[9]  = '{4'h9, 1'b0, 7'b0010000};
        vecs[10] = '{4'hA, 1'b0, 7'b0001000};
        vecs[11] = '{4'hB, 1'b0, 7'b0000011};
        vecs[12] = '{4'hC, 1'b0, 7'b1000110};
        vecs[13] = '{4'hD, 1'b0, 7'b0100001};
        vecs[14] = '{4'hE, 1'b0, 7'b0000110};
        vecs[15] = '{4'hF, 1'b0, 7'b0001110};
        vecs[16] = '{4'h8, 1'b1, 7'b1111111};
        vecs[17] = '{4'h0, 1'b1, 7'b1111111};
        vecs[18] = '{4'h7, 1'b0, 7'b1111000};
        vecs[19] = '{4'hF, 1'b1, 7'b1111111};

        rst_n = 1'b1;
        data  = 4'h9;
        blank = 1'b0;
        tick();

        // Asynchronous reset assert, no clock edge in between.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_async_lo", seg_lo, 7'h7F);
        check("reset_async_hi", seg_hi, 7'h00);
        tick();
        check("reset_hold_lo", seg_lo, 7'h7F);

        @(negedge clk);
        data  = 4'h0;
        rst_n = 1'b1;
        tick();
        check("release_d0_lo", seg_lo, 7'b1000000);
        check("release_d0_hi", seg_hi, 7'b0111111);

        for (int i = 0; i < 20; i++) begin
            data  = vecs[i].data;
            blank = vecs[i].blank;
            tick();
            check($sformatf("vec%0d_lo", i), seg_lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_hi", i), seg_hi, ~vecs[i].exp_lo);
        end

        // Latency: new data is invisible until the next edge.
        blank = 1'b0;
        data  = 4'h3;
        tick();
        check("lat_3", seg_lo, 7'b0110000);
        data = 4'h8;
        #2;
        check("lat_pre_edge", seg_lo, 7'b0110000);
        tick();
        check("lat_post_edge", seg_lo, 7'b0000000);

        // Blank priority then release.
        data  = 4'h5;
        blank = 1'b1;
        tick();
        check("blank_on", seg_lo, 7'b1111111);
        blank = 1'b0;
        #2;
        check("blank_off_pre", seg_lo, 7'b1111111);
        tick();
        check("blank_off", seg_lo, 7'b0010010);

        // Inverted polarity spot checks.
        data = 4'h1;
        tick();
        check("hi_d1", seg_hi, 7'b0000110);
        data = 4'h8;
        tick();
        check("hi_d8", seg_hi, 7'b1111111);

        // Reset mid-operation, first edge after release decodes current data.
        @(negedge clk);
        rst_n = 1'b0;
        data  = 4'h6;
        #1;
        check("mid_reset_lo", seg_lo, 7'h7F);
        check("mid_reset_hi", seg_hi, 7'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_release_lo", seg_lo, 7'b0000010);

        // Unknown data never reaches the pins as X.
        data = 4'bxxxx;
        tick();
        checks++;
        if ($isunknown(seg_lo) || $isunknown(seg_hi)) begin
            failures++;
            $display("FAIL x_data: got lo=%b hi=%b expected no X/Z",
                     seg_lo, seg_hi);
        end
        data = 4'hC;
        tick();
        check("after_x_lo", seg_lo, 7'b1000110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
